// File: rtl/reorder_pkg.sv
// Shared definitions for the reorder buffer: verdict encodings, head FSM states
// and the non-power-of-two tag wrap helper.
package reorder_pkg;

  localparam logic [1:0] ST_PENDING = 2'b00;
  localparam logic [1:0] ST_REJECT  = 2'b01;
  localparam logic [1:0] ST_ACCEPT  = 2'b11;

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    STALL
  } head_state_e;

  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned size);
    return (tag == size - 1) ? 0 : tag + 1;
  endfunction

endpackage

// File: rtl/reorder_desc_ram.sv
// Descriptor storage for the reorder buffer: one synchronous write port (tail)
// and one asynchronous read port (head).
module reorder_desc_ram #(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int DESC_WIDTH           = 64
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [TAG_WIDTH-1:0]  wr_addr,
  input  logic [DESC_WIDTH-1:0] wr_data,
  input  logic [TAG_WIDTH-1:0]  rd_addr,
  output logic [DESC_WIDTH-1:0] rd_data
);

  logic [DESC_WIDTH-1:0] mem [CIRCULAR_BUFFER_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/reorder_emitter.sv
// Reorder buffer head/tail controller: allocates tags, reads verdicts for the head
// tag and emits accepted descriptors in arrival order. Counters need REORDER_STATS_EN.
module reorder_emitter
  import reorder_pkg::*;
#(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int DESC_WIDTH           = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DESC_WIDTH-1:0] in_desc,
  output logic [TAG_WIDTH-1:0]  in_tag,
  output logic [TAG_WIDTH-1:0]  cb_reorder_tag,
  input  logic [1:0]            cb_rd_packet_status,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DESC_WIDTH-1:0] out_desc,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [TAG_WIDTH:0]    occupancy,
  output logic [31:0]           stat_accepted,
  output logic [31:0]           stat_dropped
);

  head_state_e           state, state_nxt;
  logic [TAG_WIDTH-1:0]  tail, head;
  logic                  rel_vld_p1;
  logic                  alloc, load, drop, advance, out_free;
  logic [TAG_WIDTH:0]    live;
  logic [DESC_WIDTH-1:0] ram_rd;

  reorder_desc_ram #(
    .TAG_WIDTH            (TAG_WIDTH),
    .CIRCULAR_BUFFER_SIZE (CIRCULAR_BUFFER_SIZE),
    .DESC_WIDTH           (DESC_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (alloc),
    .wr_addr (tail),
    .wr_data (in_desc),
    .rd_addr (head),
    .rd_data (ram_rd)
  );

  assign in_ready       = occupancy < (TAG_WIDTH+1)'(CIRCULAR_BUFFER_SIZE);
  assign alloc          = in_valid && in_ready;
  assign in_tag         = tail;
  assign cb_reorder_tag = head;
  assign out_free       = !out_valid || out_ready;
  // Entries not yet resolved by the head; occupancy still counts a slot whose release is in flight.
  assign live           = occupancy - {{TAG_WIDTH{1'b0}}, rel_vld_p1};
  assign advance        = load || drop;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: if (alloc || live != '0) state_nxt = WAIT;
      WAIT: begin
        case (cb_rd_packet_status)
          ST_REJECT: drop = 1'b1;
          ST_ACCEPT: begin
            if (out_free) load = 1'b1;
            else          state_nxt = STALL;
          end
          default: ;
        endcase
      end
      STALL: if (out_free) load = 1'b1;
      default: state_nxt = EMPTY;
    endcase
    if (advance) state_nxt = (live == (TAG_WIDTH+1)'(1) && !alloc) ? EMPTY : WAIT;
  end

  // Stage p0 -> p1: pointers, delayed release, head FSM and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      tail       <= '0;
      head       <= '0;
      occupancy  <= '0;
      rel_vld_p1 <= 1'b0;
      out_valid  <= 1'b0;
      out_desc   <= '0;
      out_tag    <= '0;
    end else begin
      state      <= state_nxt;
      rel_vld_p1 <= advance;
      occupancy  <= occupancy + (TAG_WIDTH+1)'(alloc) - (TAG_WIDTH+1)'(rel_vld_p1);
      if (alloc)   tail <= TAG_WIDTH'(tag_inc(32'(tail), CIRCULAR_BUFFER_SIZE));
      if (advance) head <= TAG_WIDTH'(tag_inc(32'(head), CIRCULAR_BUFFER_SIZE));
      if (load) begin
        out_valid <= 1'b1;
        out_desc  <= ram_rd;
        out_tag   <= head;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef REORDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else begin
      if (load) stat_accepted <= stat_accepted + 32'd1;
      if (drop) stat_dropped  <= stat_dropped + 32'd1;
    end
  end
`else
  assign stat_accepted = '0;
  assign stat_dropped  = '0;
`endif

endmodule

// File: tb/tb_reorder_emitter.sv
// Scoreboard bench for reorder_emitter with a behavioural packet_status table.
module tb_reorder_emitter;

  localparam int TW = 6;
  localparam int N  = 50;
  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] desc;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_desc;
  logic [TW-1:0] in_tag;
  logic [TW-1:0] cb_reorder_tag;
  logic [1:0]    cb_rd_packet_status;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_desc;
  logic [TW-1:0] out_tag;
  logic [TW:0]   occupancy;
  logic [31:0]   stat_accepted;
  logic [31:0]   stat_dropped;

  logic [1:0]    st [64];
  logic [TW-1:0] last_head;
  exp_t          q [$];
  int            checks = 0;
  int            failures = 0;

  reorder_emitter #(.TAG_WIDTH(TW), .CIRCULAR_BUFFER_SIZE(N), .DESC_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_desc             (in_desc),
    .in_tag              (in_tag),
    .cb_reorder_tag      (cb_reorder_tag),
    .cb_rd_packet_status (cb_rd_packet_status),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_desc            (out_desc),
    .out_tag             (out_tag),
    .occupancy           (occupancy),
    .stat_accepted       (stat_accepted),
    .stat_dropped        (stat_dropped)
  );

  always #5 clk = ~clk;

  assign cb_rd_packet_status = st[cb_reorder_tag];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; the status table clears a tag once the head has moved past it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cb_reorder_tag != last_head) begin
      st[last_head] = 2'b00;
      last_head = cb_reorder_tag;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < 64; i++) st[i] = 2'b00;
    last_head = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [63:0] d, input int tag);
    in_valid = 1'b1;
    in_desc  = d;
    chk("in_ready", 64'(in_ready), 64'(1));
    chk("in_tag", 64'(in_tag), 64'(tag));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic accept(input int tag, input logic [63:0] d);
    q.push_back('{desc: d, tag: TW'(tag)});
    st[tag] = 2'b11;
  endtask

  // Monitor: every output handshake is matched against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got desc %0d tag %0d with no expected entry", out_desc, out_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_desc !== e.desc || out_tag !== e.tag) begin
            failures++;
            $display("FAIL out_pkt: got desc %0d tag %0d expected desc %0d tag %0d",
                     out_desc, out_tag, e.desc, e.tag);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_desc = '0; out_ready = 1'b1;
    do_reset();
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_desc", out_desc, 64'(0));
    chk("rst_head", 64'(cb_reorder_tag), 64'(0));
    chk("rst_in_tag", 64'(in_tag), 64'(0));

    // In-order accept of tag 0
    do_alloc(64'd100, 0);
    do_alloc(64'd101, 1);
    do_alloc(64'd102, 2);
    chk("t1_occ3", 64'(occupancy), 64'(3));
    accept(0, 64'd100);
    tick();
    chk("t1_head1", 64'(cb_reorder_tag), 64'(1));
    chk("t1_out_valid", 64'(out_valid), 64'(1));
    chk("t1_out_desc", out_desc, 64'd100);
    chk("t1_occ_lag", 64'(occupancy), 64'(3));
    tick();
    chk("t1_occ2", 64'(occupancy), 64'(2));

    // Out-of-order verdicts: 2 accept, 1 reject, 0 accept
    do_reset();
    do_alloc(64'd200, 0);
    do_alloc(64'd201, 1);
    do_alloc(64'd202, 2);
    accept(2, 64'd202);
    tick();
    tick();
    chk("t2_head_hold", 64'(cb_reorder_tag), 64'(0));
    chk("t2_no_out", 64'(out_valid), 64'(0));
    st[1] = 2'b01;
    tick();
    chk("t2_head_hold2", 64'(cb_reorder_tag), 64'(0));
    q.delete();
    q.push_back('{desc: 64'd200, tag: TW'(0)});
    q.push_back('{desc: 64'd202, tag: TW'(2)});
    st[0] = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_head3", 64'(cb_reorder_tag), 64'(3));
    chk("t2_occ0", 64'(occupancy), 64'(0));
`ifdef REORDER_STATS_EN
    chk("t2_stat_acc", 64'(stat_accepted), 64'(2));
    chk("t2_stat_drop", 64'(stat_dropped), 64'(1));
`else
    chk("t2_stat_acc_off", 64'(stat_accepted), 64'(0));
    chk("t2_stat_drop_off", 64'(stat_dropped), 64'(0));
`endif

    // Fill, slot reuse timing and head wrap
    do_reset();
    for (int i = 0; i < N; i++) do_alloc(64'(300 + i), i);
    chk("t3_full_ready", 64'(in_ready), 64'(0));
    chk("t3_full_occ", 64'(occupancy), 64'(N));
    in_valid = 1'b1;
    in_desc  = 64'd999;
    accept(0, 64'd300);
    tick();
    chk("t3_ready_lag1", 64'(in_ready), 64'(0));
    tick();
    chk("t3_ready_back", 64'(in_ready), 64'(1));
    chk("t3_tag_wrap", 64'(in_tag), 64'(0));
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < N; i++) accept(i, 64'(300 + i));
    for (int i = 0; i < 60; i++) tick();
    chk("t3_head_wrap", 64'(cb_reorder_tag), 64'(0));
    chk("t3_occ1", 64'(occupancy), 64'(1));
    accept(0, 64'd999);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_occ0", 64'(occupancy), 64'(0));

    // Backpressure: head stalls, output held stable
    do_reset();
    do_alloc(64'd400, 0);
    do_alloc(64'd401, 1);
    do_alloc(64'd402, 2);
    out_ready = 1'b0;
    accept(0, 64'd400);
    accept(1, 64'd401);
    tick();
    tick();
    tick();
    chk("t4_valid", 64'(out_valid), 64'(1));
    chk("t4_desc_hold", out_desc, 64'd400);
    chk("t4_tag_hold", 64'(out_tag), 64'(0));
    chk("t4_head_stall", 64'(cb_reorder_tag), 64'(1));
    tick();
    chk("t4_desc_hold2", out_desc, 64'd400);
    out_ready = 1'b1;
    tick();
    chk("t4_next_desc", out_desc, 64'd401);
    chk("t4_next_tag", 64'(out_tag), 64'(1));
    chk("t4_next_valid", 64'(out_valid), 64'(1));
    tick();

    // Reset mid-stream with 10 occupied slots
    do_reset();
    for (int i = 0; i < 10; i++) do_alloc(64'(500 + i), i);
    chk("t5_occ10", 64'(occupancy), 64'(10));
    rst = 1'b1;
    q.delete();
    tick();
    chk("t5_occ0", 64'(occupancy), 64'(0));
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    chk("t5_head0", 64'(cb_reorder_tag), 64'(0));
    chk("t5_in_tag0", 64'(in_tag), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 64; i++) st[i] = 2'b00;
    last_head = '0;
    tick();

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
        tick();
        n++;
      end
      chk("sb_drained", 64'(q.size()), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
